// File: rtl/mem_ram_sc.sv
// mem_ram_sc: single-clock simple-dual-port data RAM.
// One write port and one registered read port. After reset, or when clr is
// pulsed, a sequencer writes zero to every word. While that runs, busy is high
// and all accesses are ignored. A read that hits the word being written in the
// same cycle returns the new data.
module mem_ram_sc #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy
);

   // DEPTH needs ADDR_W+1 bits when it equals 2**ADDR_W.
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [ADDR_W-1:0] w_clr_cnt_next;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;

   logic              w_accept;
   logic              w_wr_in_range;
   logic              w_rd_in_range;
   logic              w_wr_go;
   logic              w_rd_go;
   logic              w_collision;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   // Accesses are taken only in IDLE. A clr request drops any access issued
   // in the same cycle.
   assign w_accept      = (r_state == ST_IDLE) && !clr;
   assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
   assign w_rd_in_range = ({1'b0, rd_addr} < LP_DEPTH);
   assign w_wr_go       = w_accept && wr_en && w_wr_in_range;
   assign w_rd_go       = w_accept && rd_en;
   assign w_collision   = w_wr_go && (wr_addr == rd_addr);

   // The single memory write port is shared by the clear sequencer and the
   // user write port. The sequencer owns it for the whole of CLEAR.
   assign w_mem_we    = (r_state == ST_CLEAR) || w_wr_go;
   assign w_mem_addr  = (r_state == ST_CLEAR) ? r_clr_cnt : wr_addr;
   assign w_mem_wdata = (r_state == ST_CLEAR) ? '0 : wr_data;

   assign busy     = (r_state == ST_CLEAR);
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;

   // State register and clear counter; reset restarts the clear sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_clr_cnt <= w_clr_cnt_next;
      end
   end

   // Next-state logic: step through addresses 0..DEPTH-1, then go to IDLE.
   // A clr request in IDLE starts a new pass.
   always_comb begin
      w_state_next   = r_state;
      w_clr_cnt_next = r_clr_cnt;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_cnt == LP_LAST) begin
               w_state_next = ST_IDLE;
            end else begin
               w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            if (clr) begin
               w_state_next   = ST_CLEAR;
               w_clr_cnt_next = '0;
            end
         end
         default: begin
            w_state_next   = ST_CLEAR;
            w_clr_cnt_next = '0;
         end
      endcase
   end

   // Memory write port; no write happens in a cycle with reset asserted.
   always_ff @(posedge clk) begin
      if (!rst && w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   // Registered read with write-first bypass. An out-of-range read returns zero.
   // When no read is accepted, rd_data holds its previous value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else if (w_rd_go) begin
         r_rd_valid <= 1'b1;
         if (!w_rd_in_range) begin
            r_rd_data <= '0;
         end else if (w_collision) begin
            r_rd_data <= wr_data;
         end else begin
            r_rd_data <= r_mem[rd_addr];
         end
      end else begin
         r_rd_valid <= 1'b0;
      end
   end

endmodule
